// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues in-order bus fetches, buffers up to
// two in-flight/returned instructions and drives a registered IF->ID output.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  stall,
  input  logic        ctrl_jump_flag,
  input  logic [31:0] ctrl_jump_addr,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  output logic [31:0] if_inst,
  output logic [31:0] if_inst_addr,
  output logic        if_valid,
  output logic        o_dbg_state
);

  // Bus handshake: a request transfers on any edge where ibus_req && ibus_gnt;
  // ibus_req/ibus_addr stay stable until granted unless a jump or stall withdraws
  // them. Each granted request gets exactly one ibus_rvalid pulse, in grant order.
  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [1:0]  r_out;
  logic [1:0]  r_disc;
  logic [1:0]  r_cnt;
  logic [1:0]  r_nfill;
  logic        r_head;
  logic [31:0] r_buf_addr [2];
  logic [31:0] r_buf_inst [2];
  logic [31:0] r_if_inst;
  logic [31:0] r_if_inst_addr;
  logic        r_if_valid;

  logic        w_resp;
  logic        w_pop;
  logic [1:0]  w_buffered;
  logic [2:0]  w_occupancy;
  logic        w_grant;
  logic        w_discard;
  logic        w_fill;
  logic        w_fill_idx;
  logic        w_alloc_idx;
  logic [1:0]  w_out_nxt;
  logic [1:0]  w_disc_nxt;
  logic        w_unused;

  assign w_unused = ^stall[5:2];

  // A response with nothing outstanding belongs to a pre-reset request.
  assign w_resp = ibus_rvalid & (r_out != 2'd0);

  // Filled entries always form a prefix starting at the head.
  assign w_pop = ~stall[1] & ~ctrl_jump_flag & (r_nfill != 2'd0);

  // The entry handed to decode this cycle frees its slot for a new request.
  assign w_buffered  = r_nfill - {1'b0, w_pop};
  assign w_occupancy = {1'b0, r_out} + {1'b0, w_buffered};

  assign ibus_req  = rst_n & ~ctrl_jump_flag & ~stall[0] & (w_occupancy < 3'd2);
  assign ibus_addr = r_pc;
  assign w_grant   = ibus_req & ibus_gnt;

  assign w_discard   = w_resp & (r_disc != 2'd0);
  assign w_fill      = w_resp & (r_disc == 2'd0) & ~ctrl_jump_flag;
  assign w_fill_idx  = r_head + r_nfill[0];
  assign w_alloc_idx = r_head + r_cnt[0];
  assign w_out_nxt   = r_out + {1'b0, w_grant} - {1'b0, w_resp};

  always_comb begin
    w_state_nxt = r_state;
    w_disc_nxt  = r_disc;
    if (ctrl_jump_flag) begin
      // Every request still in flight after this edge predates the redirect.
      w_disc_nxt  = w_out_nxt;
      w_state_nxt = (w_out_nxt != 2'd0) ? S_FLUSH : S_RUN;
    end else begin
      if (w_discard) begin
        w_disc_nxt = r_disc - 2'd1;
      end
      if ((r_state == S_FLUSH) && (w_disc_nxt == 2'd0)) begin
        w_state_nxt = S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_out   <= 2'd0;
      r_disc  <= 2'd0;
      r_cnt   <= 2'd0;
      r_nfill <= 2'd0;
      r_head  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_disc  <= w_disc_nxt;
      if (ctrl_jump_flag) begin
        r_pc    <= {ctrl_jump_addr[31:2], 2'b00};
        r_cnt   <= 2'd0;
        r_nfill <= 2'd0;
      end else begin
        if (w_grant) begin
          r_pc <= r_pc + 32'd4;
        end
        r_cnt   <= r_cnt + {1'b0, w_grant} - {1'b0, w_pop};
        r_nfill <= r_nfill + {1'b0, w_fill} - {1'b0, w_pop};
        r_head  <= r_head ^ w_pop;
      end
    end
  end

  // Buffer payload carries no control meaning, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_buf_addr[w_alloc_idx] <= r_pc;
    end
    if (w_fill) begin
      r_buf_inst[w_fill_idx] <= ibus_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_if_inst      <= NOP_INST;
      r_if_inst_addr <= 32'd0;
      r_if_valid     <= 1'b0;
    end else if (ctrl_jump_flag || !stall[1]) begin
      if (w_pop) begin
        r_if_inst      <= r_buf_inst[r_head];
        r_if_inst_addr <= r_buf_addr[r_head];
        r_if_valid     <= 1'b1;
      end else begin
        r_if_inst      <= NOP_INST;
        r_if_inst_addr <= 32'd0;
        r_if_valid     <= 1'b0;
      end
    end
  end

  assign if_inst      = r_if_inst;
  assign if_inst_addr = r_if_inst_addr;
  assign if_valid     = r_if_valid;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: streaming, stalls, redirects with in-flight
// requests, grant back-pressure, PC wrap and reset during a flush.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  stall;
  logic        ctrl_jump_flag;
  logic [31:0] ctrl_jump_addr;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_gnt;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;
  logic [31:0] if_inst;
  logic [31:0] if_inst_addr;
  logic        if_valid;
  logic        o_dbg_state;

  int errors = 0;
  int checks = 0;
  bit auto_resp;

  if_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .ctrl_jump_flag (ctrl_jump_flag),
    .ctrl_jump_addr (ctrl_jump_addr),
    .ibus_req       (ibus_req),
    .ibus_addr      (ibus_addr),
    .ibus_gnt       (ibus_gnt),
    .ibus_rvalid    (ibus_rvalid),
    .ibus_rdata     (ibus_rdata),
    .if_inst        (if_inst),
    .if_inst_addr   (if_inst_addr),
    .if_valid       (if_valid),
    .o_dbg_state    (o_dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock: sample the handshake just before the edge, return 1 ns after it.
  // In auto mode the memory answers every grant in the following cycle.
  task automatic cyc();
    logic        g;
    logic [31:0] a;
    #2;
    g = ibus_req & ibus_gnt;
    a = ibus_addr;
    @(posedge clk);
    #1;
    if (auto_resp) begin
      ibus_rvalid = g;
      ibus_rdata  = g ? mem(a) : 32'h0;
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 6'd0; ctrl_jump_flag = 1'b0; ctrl_jump_addr = 32'd0;
    ibus_gnt = 1'b1; ibus_rvalid = 1'b0; ibus_rdata = 32'd0; auto_resp = 1'b1;

    // Reset values
    cyc(); cyc(); settle();
    chk("rst_req", ibus_req, 0);
    chk("rst_addr", ibus_addr, 32'h0);
    chk("rst_valid", if_valid, 0);
    chk("rst_inst", if_inst, NOP);
    chk("rst_iaddr", if_inst_addr, 32'h0);
    chk("rst_state", o_dbg_state, 0);
    rst_n = 1'b1;

    // Back-to-back streaming
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("a_req", ibus_req, 1);
      chk("a_addr", ibus_addr, 32'(4 * k));
      cyc();
      if (k >= 2) begin
        chk("a_valid", if_valid, 1);
        chk("a_iaddr", if_inst_addr, 32'(4 * (k - 2)));
        chk("a_inst", if_inst, mem(32'(4 * (k - 2))));
      end else begin
        chk("a_bubble", if_valid, 0);
      end
    end

    // Stall issue and output for three cycles
    stall = 6'b000111;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("s_req", ibus_req, 0);
      chk("s_addr", ibus_addr, 32'd32);
      cyc();
      chk("s_iaddr", if_inst_addr, 32'd20);
      chk("s_inst", if_inst, mem(32'd20));
      chk("s_valid", if_valid, 1);
    end
    stall = 6'd0;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("r_req", ibus_req, 1);
      chk("r_addr", ibus_addr, 32'(32 + 4 * k));
      cyc();
      chk("r_iaddr", if_inst_addr, 32'(24 + 4 * k));
      chk("r_inst", if_inst, mem(32'(24 + 4 * k)));
    end

    // Jump with two requests outstanding; responses driven by hand
    rst_n = 1'b0; auto_resp = 1'b0; ibus_rvalid = 1'b0; cyc(); rst_n = 1'b1;
    settle(); chk("b_req0", ibus_req, 1); chk("b_addr0", ibus_addr, 32'h0); cyc();
    settle(); chk("b_req1", ibus_req, 1); chk("b_addr1", ibus_addr, 32'h4); cyc();
    settle(); chk("b_req2", ibus_req, 0);
    ctrl_jump_flag = 1'b1; ctrl_jump_addr = 32'h0000_0103;
    settle(); chk("b_req_j", ibus_req, 0);
    cyc(); ctrl_jump_flag = 1'b0;
    settle();
    chk("b_addr_j", ibus_addr, 32'h100);
    chk("b_req_fl", ibus_req, 0);
    chk("b_state_fl", o_dbg_state, 1);
    chk("b_valid_j", if_valid, 0);
    chk("b_inst_j", if_inst, NOP);
    ibus_rvalid = 1'b1; ibus_rdata = mem(32'h0); cyc();
    settle();
    chk("b_state_fl2", o_dbg_state, 1);
    chk("b_req4", ibus_req, 1);
    chk("b_addr4", ibus_addr, 32'h100);
    ibus_rdata = mem(32'h4); cyc();
    settle();
    chk("b_state_run", o_dbg_state, 0);
    chk("b_valid5", if_valid, 0);
    chk("b_addr5", ibus_addr, 32'h104);
    ibus_rdata = mem(32'h100); cyc();
    settle();
    chk("b_addr6", ibus_addr, 32'h108);
    ibus_rdata = mem(32'h104); cyc();
    chk("b_valid6", if_valid, 1);
    chk("b_iaddr6", if_inst_addr, 32'h100);
    chk("b_inst6", if_inst, mem(32'h100));
    ibus_rvalid = 1'b0;
    settle(); chk("b_req7", ibus_req, 1); chk("b_addr7", ibus_addr, 32'h10C); cyc();
    chk("b_iaddr7", if_inst_addr, 32'h104);

    // Response arriving in the jump cycle
    settle(); chk("b_req8", ibus_req, 0);
    ctrl_jump_flag = 1'b1; ctrl_jump_addr = 32'h0000_0200;
    ibus_rvalid = 1'b1; ibus_rdata = mem(32'h108);
    cyc(); ctrl_jump_flag = 1'b0; ibus_rvalid = 1'b0;
    chk("b_valid8", if_valid, 0);
    chk("b_inst8", if_inst, NOP);
    chk("b_iaddr8", if_inst_addr, 32'h0);
    settle();
    chk("b_state9", o_dbg_state, 1);
    chk("b_addr9", ibus_addr, 32'h200);
    chk("b_req9", ibus_req, 1);
    ibus_rvalid = 1'b1; ibus_rdata = mem(32'h10C); cyc();
    settle();
    chk("b_state10", o_dbg_state, 0);
    chk("b_valid10", if_valid, 0);
    chk("b_addr10", ibus_addr, 32'h204);
    ibus_rdata = mem(32'h200); cyc();
    ibus_rvalid = 1'b0; cyc();
    chk("b_valid11", if_valid, 1);
    chk("b_iaddr11", if_inst_addr, 32'h200);
    chk("b_inst11", if_inst, mem(32'h200));

    // Grant withheld, then PC wrap
    rst_n = 1'b0; auto_resp = 1'b1; ibus_rvalid = 1'b0; ibus_gnt = 1'b0; cyc(); rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("c_req", ibus_req, 1);
      chk("c_addr", ibus_addr, 32'h0);
      cyc();
      chk("c_valid", if_valid, 0);
    end
    ctrl_jump_flag = 1'b1; ctrl_jump_addr = 32'hFFFF_FFFF; cyc(); ctrl_jump_flag = 1'b0;
    chk("c_state", o_dbg_state, 0);
    ibus_gnt = 1'b1;
    settle(); chk("c_addr_top", ibus_addr, 32'hFFFF_FFFC); chk("c_req_top", ibus_req, 1); cyc();
    settle(); chk("c_addr_wrap", ibus_addr, 32'h0); cyc();
    settle(); chk("c_addr4", ibus_addr, 32'h4); cyc();
    chk("c_valid8", if_valid, 1);
    chk("c_iaddr8", if_inst_addr, 32'hFFFF_FFFC);
    chk("c_inst8", if_inst, mem(32'hFFFF_FFFC));

    // Reset while flushing
    auto_resp = 1'b0; ibus_rvalid = 1'b0;
    ctrl_jump_flag = 1'b1; ctrl_jump_addr = 32'h0000_0300; cyc(); ctrl_jump_flag = 1'b0;
    settle(); chk("d_state_fl", o_dbg_state, 1);
    rst_n = 1'b0; cyc(); settle();
    chk("d_valid", if_valid, 0);
    chk("d_inst", if_inst, NOP);
    chk("d_iaddr", if_inst_addr, 32'h0);
    chk("d_state", o_dbg_state, 0);
    chk("d_addr", ibus_addr, 32'h0);
    chk("d_req", ibus_req, 0);
    rst_n = 1'b1; auto_resp = 1'b1;
    ibus_rvalid = 1'b1; ibus_rdata = 32'hDEAD_BEEF;
    settle(); chk("d_req0", ibus_req, 1); chk("d_addr0", ibus_addr, 32'h0);
    cyc(); cyc(); cyc();
    chk("d_valid3", if_valid, 1);
    chk("d_iaddr3", if_inst_addr, 32'h0);
    chk("d_inst3", if_inst, mem(32'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
